// File: rtl/vpg_pkg.sv
// -----------------------------------------------------------------------------
// vpg_pkg
// Shared types for the VGA pattern-generator sequencer:
//   - pattern_t : 3-bit pattern code written to the generator's select register
//   - PAT_*     : named pattern codes understood by the generator
//   - state_e   : sequencer FSM states
//   - pat_next / pat_wrap : pattern arithmetic modulo the number of patterns
// -----------------------------------------------------------------------------
package vpg_pkg;

    typedef logic [2:0] pattern_t;

    localparam pattern_t PAT_SCALE = 3'd0;
    localparam pattern_t PAT_RED   = 3'd1;
    localparam pattern_t PAT_GREEN = 3'd2;
    localparam pattern_t PAT_BLUE  = 3'd3;
    localparam pattern_t PAT_WHITE = 3'd4;
    localparam pattern_t PAT_BLACK = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    // Next pattern in the cycle, wrapping the last code back to 0.
    function automatic pattern_t pat_next(input pattern_t p, input int unsigned n);
        if (32'(p) >= (n - 32'd1)) begin
            return 3'd0;
        end else begin
            return p + 3'd1;
        end
    endfunction

    // Fold an arbitrary 3-bit code into the range 0..n-1.
    function automatic pattern_t pat_wrap(input pattern_t p, input int unsigned n);
        return pattern_t'(32'(p) % n);
    endfunction

endpackage

// File: rtl/vpg_vsync_edge.sv
// -----------------------------------------------------------------------------
// vpg_vsync_edge
// Brings the generator's vsync (vga_clk domain) into the system clock domain
// through a 2-flop synchroniser, then detects the frame edge selected by
// VS_ACTIVE_LOW (1: falling edge, 0: rising edge). The tick is registered,
// so it appears 3 clk after the input edge.
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   vga_vs_i     asynchronous vsync input
//   frame_tick_o one-cycle pulse per detected frame edge
// -----------------------------------------------------------------------------
module vpg_vsync_edge #(
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic vga_vs_i,
    output logic frame_tick_o
);

    // Reset to the inactive vsync level so release never fakes a frame edge.
    localparam logic VS_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic vs_meta_q;
    logic vs_sync_q;
    logic vs_prev_q;
    logic tick_q;
    logic edge_s;

    assign edge_s = VS_ACTIVE_LOW ? (vs_prev_q & ~vs_sync_q)
                                  : (~vs_prev_q & vs_sync_q);

    // Synchroniser, edge history and registered frame tick.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_meta_q <= VS_IDLE;
            vs_sync_q <= VS_IDLE;
            vs_prev_q <= VS_IDLE;
            tick_q    <= 1'b0;
        end else begin
            vs_meta_q <= vga_vs_i;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            tick_q    <= edge_s;
        end
    end

    assign frame_tick_o = tick_q;

endmodule

// File: rtl/vpg_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// vpg_pattern_sequencer
// Autonomously steps the VGA pattern generator's select register through
// codes 0..NUM_PATTERNS-1, holding each for FRAMES_PER_PATTERN vsync frames.
// Build option: define VPG_SEQ_READBACK_EN to read back each write, retry up
// to MAX_RETRY times and flag a sticky err on persistent mismatch. Without it
// the register is written blind, m_read and err stay 0.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   enable, hold                  run sequence / freeze frame counting
//   force_valid, force_pattern    one-cycle jump to a given pattern
//   vga_vs                        generator vsync (asynchronous)
//   m_cs_n, m_write, m_read,
//   m_writedata, m_readdata       generator slave interface
//   current_pattern               pattern last committed
//   frame_tick                    one pulse per detected frame
//   err, err_clr                  sticky readback failure and its clear
// -----------------------------------------------------------------------------
module vpg_pattern_sequencer
    import vpg_pkg::*;
#(
    parameter int NUM_PATTERNS       = 6,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int VS_ACTIVE_LOW      = 1,
    parameter int MAX_RETRY          = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       hold,
    input  logic       force_valid,
    input  logic [2:0] force_pattern,
    input  logic       vga_vs,
    output logic       m_cs_n,
    output logic       m_write,
    output logic       m_read,
    output logic [7:0] m_writedata,
    input  logic [7:0] m_readdata,
    output logic [2:0] current_pattern,
    output logic       frame_tick,
    output logic       err,
    input  logic       err_clr
);

    state_e     state_q, state_d;
    pattern_t   pat_q, pat_d;
    pattern_t   cur_q, cur_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0] retry_q, retry_d;
    logic       err_q, err_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [7:0] wdata_q, wdata_d;
    logic       frame_tick_s;

    // Inputs only consumed by the readback build.
    logic [8:0] unused_inputs_s;
    assign unused_inputs_s = {err_clr, m_readdata};

`ifndef VPG_SEQ_READBACK_EN
    localparam int unused_max_retry_c = MAX_RETRY;
`endif

    vpg_vsync_edge #(
        .VS_ACTIVE_LOW (VS_ACTIVE_LOW != 0)
    ) u_vsync_edge (
        .clk_i        (clk),
        .rst_n_i      (reset_n),
        .vga_vs_i     (vga_vs),
        .frame_tick_o (frame_tick_s)
    );

    // Next-state, pattern, counters and strobe decode.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        err_d   = err_q;
`ifdef VPG_SEQ_READBACK_EN
        if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (enable) begin
                    state_d = ST_WRITE;
                    if (force_valid) begin
                        pat_d = pat_wrap(force_pattern, NUM_PATTERNS);
                    end else begin
                        pat_d = cur_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cur_d = pat_q;
`ifdef VPG_SEQ_READBACK_EN
                state_d = ST_READ;
`else
                if (enable) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end
`endif
            end
`ifdef VPG_SEQ_READBACK_EN
            ST_READ: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (m_readdata[2:0] == pat_q) begin
                    retry_d = 8'd0;
                    state_d = enable ? ST_WAIT : ST_IDLE;
                end else if (retry_q < 8'(MAX_RETRY)) begin
                    if (enable) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_WRITE;
                    end else begin
                        retry_d = 8'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Set beats a same-cycle err_clr.
                    err_d   = 1'b1;
                    retry_d = 8'd0;
                    state_d = enable ? ST_WAIT : ST_IDLE;
                end
            end
`endif
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (force_valid) begin
                    // A force wins over a terminal frame tick in the same cycle.
                    pat_d   = pat_wrap(force_pattern, NUM_PATTERNS);
                    cnt_d   = 16'd0;
                    state_d = ST_WRITE;
                end else if (frame_tick_s && !hold) begin
                    if (cnt_q == 16'(FRAMES_PER_PATTERN - 1)) begin
                        cnt_d   = 16'd0;
                        pat_d   = pat_next(pat_q, NUM_PATTERNS);
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        wr_d   = (state_d == ST_WRITE);
`ifdef VPG_SEQ_READBACK_EN
        rd_d   = (state_d == ST_READ);
`else
        rd_d   = 1'b0;
`endif
        cs_n_d = ~(wr_d | rd_d);
        if (wr_d) begin
            wdata_d = {5'b00000, pat_d};
        end else begin
            wdata_d = wdata_q;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pat_q   <= 3'd0;
            cur_q   <= 3'd0;
            cnt_q   <= 16'd0;
            retry_q <= 8'd0;
            err_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            cs_n_q  <= cs_n_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    assign m_cs_n          = cs_n_q;
    assign m_write         = wr_q;
    assign m_read          = rd_q;
    assign m_writedata     = wdata_q;
    assign current_pattern = cur_q;
    assign frame_tick      = frame_tick_s;
    assign err             = err_q;

endmodule
